mil_bc_tx_sequencer: RTL and testbench
======================================

# mil_bc_tx_sequencer

Bus-controller message sequencer for the MIL-STD-1553B transmit path. It takes one command word, decodes how many data words must follow, fetches them from the message word buffer and feeds the Manchester transmitter one word at a time over its `EN`/`BUSY` handshake. It sits between the BC host logic and `mil_transmitter` and is the only block that drives the transmitter's `iEN`/`iCD`/`iDATA`.

## Interface
Parameters:
- `BUSY_TO`, default 4: cycles allowed after `oTX_EN` for `iTX_BUSY` to rise before a timeout is declared (range 2..15).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `iCLK`  in  1  clock.
  - `iRESET`  in  1  synchronous active-high reset.
- Host side:
  - `iSTART`  in  1  one-cycle request to send a message; ignored unless `oREADY`.
  - `iCMD`  in  16  command word, sampled when `iSTART & oREADY`.
  - `iABORT`  in  1  stop the message after the word currently on the bus.
  - `oREADY`  out  1  high when idle and `iTX_BUSY` is low.
  - `oDONE`  out  1  one-cycle pulse at message end.
  - `oSTATUS`  out  2  valid with `oDONE`: 00 = ok, 01 = busy timeout, 10 = aborted.
  - `oWORDS`  out  6  data words sent in the last message; held until the next start.
- Buffer side:
  - `oRD`  out  1  read strobe.
  - `oADDR`  out  5  data word index.
  - `iRDATA`  in  16  read data, valid exactly one cycle after `oRD`.
- Transmitter side:
  - `oTX_EN`  out  1  one-cycle load pulse.
  - `oTX_CD`  out  1  1 = command/status sync, 0 = data sync.
  - `oTX_DATA`  out  16  word to send.
  - `iTX_BUSY`  in  1  transmitter busy.

## Operation
- Data word count N is decoded from `iCMD`:
  - T/R bit `iCMD[10]` = 1: N = 0.
  - Subaddress `iCMD[9:5]` = 00000 or 11111 (mode code): N = `iCMD[4]` ? 1 : 0.
  - Otherwise N = `iCMD[4:0]`, with 0 meaning 32. N is held in 6 bits.
- States:
  - `IDLE`: on `iSTART & oREADY`, latch the command, N and index = 0, and clear `oWORDS` → `CMD_LOAD`.
  - `CMD_LOAD`: `oTX_EN` = 1, `oTX_CD` = 1, `oTX_DATA` = command → `WAIT_RISE`.
  - `WAIT_RISE`:
    - If `iTX_BUSY` = 1 → `WAIT_FALL`.
    - Else, once the timeout counter reaches `BUSY_TO` → `DONE` with status 01.
  - `WAIT_FALL`: when `iTX_BUSY` = 0:
    - abort flag set → `DONE` with status 10;
    - else index == N → `DONE` with status 00;
    - else → `FETCH`.
  - `FETCH`: `oRD` = 1, `oADDR` = index[4:0] → `CAPTURE`.
  - `CAPTURE`: register `iRDATA` → `DATA_LOAD`.
  - `DATA_LOAD`: `oTX_EN` = 1, `oTX_CD` = 0, `oTX_DATA` = captured word; index++ and `oWORDS`++ → `WAIT_RISE`.
  - `DONE`: `oDONE` = 1 for one cycle → `IDLE`.
- Abort:
  - `iABORT` in any non-`IDLE` state sets a sticky flag; it is cleared on entry to `IDLE`.
  - The word already loaded into the transmitter always completes.
  - An abort seen in `FETCH` or `CAPTURE` still sends that data word.
  - `iABORT` in `IDLE` is ignored.
- `iSTART` while not `oREADY` is dropped; it is not queued.

## Timing
- Reset values: `oTX_EN`, `oTX_CD`, `oRD`, `oDONE` = 0; `oTX_DATA`, `oADDR`, `oWORDS`, `oSTATUS` = 0; state = `IDLE`.
- `oREADY` = (`IDLE` & ~`iTX_BUSY`). After a reset mid-message the transmitter may still be running, so no new start is accepted until its busy drops.
- All outputs except `oREADY` are registered.
- `iSTART` at cycle 0 → `oTX_EN` with the command at cycle 1.
- `iTX_BUSY` sampled low at cycle t in `WAIT_FALL`:
  - `oRD` at t+1;
  - `oTX_EN` with the data word at t+3;
  - or `oDONE` at t+1 if the message has ended.
- Timeout counter resets on entry to `WAIT_RISE`. `iTX_BUSY` never rising → `oDONE` with status 01 at cycle `BUSY_TO`+2 after the `oTX_EN` cycle.
- `oTX_EN` is never asserted while `iTX_BUSY` is high.
- Index wrap: N = 32 uses `oADDR` 0..31. The terminal check uses the 6-bit index, so there is no wrap to 0.

## Structure
- Shared package `mil_pkg`: sequencer state encoding; status codes `ST_OK`, `ST_TIMEOUT`, `ST_ABORT`; command field positions (T/R bit 10, subaddress 9:5, count 4:0).
- One natural sub-module, `mil_cmd_decode`: combinational command word → N (6 bits), reused by the RT side.

## Test plan
- Receive command 0x0823 (SA 1, count 3) with buffer {0xAAAA, 0x5555, 0x1234}:
  - four `oTX_EN` pulses, CD pattern 1,0,0,0, data in order;
  - `oADDR` 0,1,2;
  - `oDONE` with `oSTATUS` = 00 and `oWORDS` = 3.
- Transmit command 0x0C23 (T/R = 1): one `oTX_EN`, no `oRD`, `oDONE` status 00, `oWORDS` = 0.
- Mode code 0x0012 (SA 0, bit 4 = 1) → one data word from addr 0. Mode code 0x03E2 → command word only.
- Count 0 (0x0820): 32 data words, `oADDR` 0..31, `oWORDS` = 32.
- Busy never rises after the command: `oDONE` status 01 exactly `BUSY_TO`+2 cycles after `oTX_EN`; `oREADY` high the following cycle.
- `iABORT` during the second data word of count 5: that word completes, no third `oTX_EN`, status 10, `oWORDS` = 2. Then `iRESET` mid-word: outputs at reset values next cycle and `oREADY` low until `iTX_BUSY` falls.

Source files
------------

// File: rtl/mil_pkg.sv
// rtl/mil_pkg.sv - shared MIL-STD-1553B types: sequencer states, status codes, command fields
package mil_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CMD_LOAD,
        SEQ_WAIT_RISE,
        SEQ_WAIT_FALL,
        SEQ_FETCH,
        SEQ_CAPTURE,
        SEQ_DATA_LOAD,
        SEQ_DONE
    } seq_state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    localparam int CMD_TR_BIT  = 10;
    localparam int CMD_SA_MSB  = 9;
    localparam int CMD_SA_LSB  = 5;
    localparam int CMD_CNT_MSB = 4;
    localparam int CMD_CNT_LSB = 0;

endpackage

// File: rtl/mil_bc_tx_sequencer_if.sv
// rtl/mil_bc_tx_sequencer_if.sv - host, word buffer and transmitter signals of the BC sequencer
interface mil_bc_tx_sequencer_if;

    logic        iSTART;
    logic [15:0] iCMD;
    logic        iABORT;
    logic        oREADY;
    logic        oDONE;
    logic [1:0]  oSTATUS;
    logic [5:0]  oWORDS;

    logic        oRD;
    logic [4:0]  oADDR;
    logic [15:0] iRDATA;

    logic        oTX_EN;
    logic        oTX_CD;
    logic [15:0] oTX_DATA;
    logic        iTX_BUSY;

    modport master (
        input  iSTART, iCMD, iABORT, iRDATA, iTX_BUSY,
        output oREADY, oDONE, oSTATUS, oWORDS, oRD, oADDR, oTX_EN, oTX_CD, oTX_DATA
    );

    modport slave (
        output iSTART, iCMD, iABORT, iRDATA, iTX_BUSY,
        input  oREADY, oDONE, oSTATUS, oWORDS, oRD, oADDR, oTX_EN, oTX_CD, oTX_DATA
    );

endinterface

// File: rtl/mil_cmd_decode.sv
// rtl/mil_cmd_decode.sv - command word to data word count (0..32); mode codes carry at most one word
module mil_cmd_decode
    import mil_pkg::*;
(
    input  logic [CMD_TR_BIT:0] cmd_i,
    output logic [5:0]          n_o
);

    logic [4:0] sa;
    logic [4:0] cnt;

    assign sa  = cmd_i[CMD_SA_MSB:CMD_SA_LSB];
    assign cnt = cmd_i[CMD_CNT_MSB:CMD_CNT_LSB];

    always_comb begin
        n_o = 6'd0;
        if (cmd_i[CMD_TR_BIT]) begin
            n_o = 6'd0;
        end else if (sa == 5'd0 || sa == 5'h1F) begin
            n_o = {5'd0, cnt[4]};
        end else if (cnt == 5'd0) begin
            n_o = 6'd32;
        end else begin
            n_o = {1'b0, cnt};
        end
    end

endmodule

// File: rtl/mil_bc_tx_sequencer.sv
// rtl/mil_bc_tx_sequencer.sv - sends one command word plus its data words to the Manchester transmitter
module mil_bc_tx_sequencer
    import mil_pkg::*;
#(
    parameter int BUSY_TO = 4
)
(
    input  logic                  iCLK,
    input  logic                  iRESET,
    mil_bc_tx_sequencer_if.master bus
);

    seq_state_e  state_q;
    logic [5:0]  n_q;
    logic [5:0]  idx_q;
    logic [5:0]  words_q;
    logic [1:0]  status_q;
    logic        abort_q;
    logic [3:0]  to_cnt_q;
    logic        tx_en_q;
    logic        tx_cd_q;
    logic [15:0] tx_data_q;
    logic        rd_q;
    logic [4:0]  addr_q;
    logic        done_q;
    logic [5:0]  n_d;

    mil_cmd_decode u_cmd_decode (
        .cmd_i (bus.iCMD[CMD_TR_BIT:0]),
        .n_o   (n_d)
    );

    // A transmitter left running by a reset mid-word still blocks new starts.
    assign bus.oREADY   = (state_q == SEQ_IDLE) && !bus.iTX_BUSY;
    assign bus.oDONE    = done_q;
    assign bus.oSTATUS  = status_q;
    assign bus.oWORDS   = words_q;
    assign bus.oRD      = rd_q;
    assign bus.oADDR    = addr_q;
    assign bus.oTX_EN   = tx_en_q;
    assign bus.oTX_CD   = tx_cd_q;
    assign bus.oTX_DATA = tx_data_q;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q   <= SEQ_IDLE;
            n_q       <= 6'd0;
            idx_q     <= 6'd0;
            words_q   <= 6'd0;
            status_q  <= ST_OK;
            abort_q   <= 1'b0;
            to_cnt_q  <= 4'd0;
            tx_en_q   <= 1'b0;
            tx_cd_q   <= 1'b0;
            tx_data_q <= 16'd0;
            rd_q      <= 1'b0;
            addr_q    <= 5'd0;
            done_q    <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;

            if (state_q != SEQ_IDLE && bus.iABORT) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                SEQ_IDLE: begin
                    if (bus.iSTART && !bus.iTX_BUSY) begin
                        n_q       <= n_d;
                        idx_q     <= 6'd0;
                        words_q   <= 6'd0;
                        tx_en_q   <= 1'b1;
                        tx_cd_q   <= 1'b1;
                        tx_data_q <= bus.iCMD;
                        state_q   <= SEQ_CMD_LOAD;
                    end
                end
                SEQ_CMD_LOAD: begin
                    to_cnt_q <= 4'd0;
                    state_q  <= SEQ_WAIT_RISE;
                end
                SEQ_WAIT_RISE: begin
                    if (bus.iTX_BUSY) begin
                        state_q <= SEQ_WAIT_FALL;
                    end else if (to_cnt_q == 4'(BUSY_TO)) begin
                        status_q <= ST_TIMEOUT;
                        done_q   <= 1'b1;
                        state_q  <= SEQ_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 4'd1;
                    end
                end
                SEQ_WAIT_FALL: begin
                    if (!bus.iTX_BUSY) begin
                        if (abort_q) begin
                            status_q <= ST_ABORT;
                            done_q   <= 1'b1;
                            state_q  <= SEQ_DONE;
                        end else if (idx_q == n_q) begin
                            status_q <= ST_OK;
                            done_q   <= 1'b1;
                            state_q  <= SEQ_DONE;
                        end else begin
                            rd_q    <= 1'b1;
                            addr_q  <= idx_q[4:0];
                            state_q <= SEQ_FETCH;
                        end
                    end
                end
                SEQ_FETCH: begin
                    state_q <= SEQ_CAPTURE;
                end
                // Buffer data is valid in the cycle after the read strobe, i.e. now.
                SEQ_CAPTURE: begin
                    tx_en_q   <= 1'b1;
                    tx_cd_q   <= 1'b0;
                    tx_data_q <= bus.iRDATA;
                    state_q   <= SEQ_DATA_LOAD;
                end
                SEQ_DATA_LOAD: begin
                    idx_q    <= idx_q + 6'd1;
                    words_q  <= words_q + 6'd1;
                    to_cnt_q <= 4'd0;
                    state_q  <= SEQ_WAIT_RISE;
                end
                SEQ_DONE: begin
                    abort_q <= 1'b0;
                    state_q <= SEQ_IDLE;
                end
                default: begin
                    state_q <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mil_bc_tx_sequencer.sv
// tb/tb_mil_bc_tx_sequencer.sv - randomized bench for mil_bc_tx_sequencer with transmitter/buffer models
module tb_mil_bc_tx_sequencer;

    localparam int BUSY_TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mil_bc_tx_sequencer_if bus();

    mil_bc_tx_sequencer #(.BUSY_TO(BUSY_TO)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] mem [32];
    int          cyc = 0;
    always @(posedge clk) cyc++;

    logic [16:0] en_q[$];
    int          en_cyc[$];
    int          rd_q[$];
    bit          got_done = 0;
    int          done_cyc = 0;
    logic [1:0]  done_st = 2'b00;
    logic [5:0]  done_words = 6'd0;
    bit          no_busy = 0;
    int          rise_wait = 0;
    int          busy_cnt = 0;
    bit          rd_prev = 0;
    logic [4:0]  addr_prev = 5'd0;
    int          busy_viol = 0;

    // Monitor first, then the buffer and transmitter responders, all on the falling edge.
    always @(negedge clk) begin
        if (bus.oTX_EN === 1'b1) begin
            en_q.push_back({bus.oTX_CD, bus.oTX_DATA});
            en_cyc.push_back(cyc);
            if (bus.iTX_BUSY === 1'b1) busy_viol++;
        end
        if (bus.oRD === 1'b1) rd_q.push_back(int'(bus.oADDR));
        if (bus.oDONE === 1'b1) begin
            got_done   = 1;
            done_cyc   = cyc;
            done_st    = bus.oSTATUS;
            done_words = bus.oWORDS;
        end
        bus.iRDATA = rd_prev ? mem[addr_prev] : 16'($urandom);
        rd_prev    = (bus.oRD === 1'b1);
        addr_prev  = bus.oADDR;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.iTX_BUSY = 1'b0;
        end else if (rise_wait > 0) begin
            rise_wait--;
            if (rise_wait == 0) begin
                bus.iTX_BUSY = 1'b1;
                busy_cnt     = 3 + int'($urandom % 4);
            end
        end else begin
            bus.iTX_BUSY = 1'b0;
        end
        if (bus.oTX_EN === 1'b1 && !no_busy) rise_wait = 1 + int'($urandom % 3);
    end

    function automatic int model_n(input logic [15:0] c);
        int v, sa, cnt;
        v   = int'(c);
        sa  = (v >> 5) % 32;
        cnt = v % 32;
        if ((v >> 10) % 2 == 1) return 0;
        if (sa == 0 || sa == 31) return (cnt >= 16) ? 1 : 0;
        return (cnt == 0) ? 32 : cnt;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [15:0] cmd, output int sc);
        int k = 0;
        while (bus.oREADY !== 1'b1 && k < 500) begin
            step();
            k++;
        end
        if (k >= 500) chk("ready_before_start", 32'(bus.oREADY), 1);
        en_q.delete();
        en_cyc.delete();
        rd_q.delete();
        got_done   = 0;
        bus.iCMD   = cmd;
        bus.iSTART = 1'b1;
        sc         = cyc;
        step();
        bus.iSTART = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!got_done && k < 3000) begin
            step();
            k++;
        end
        chk("done_seen", 32'(got_done), 1);
    endtask

    task automatic run_msg(input logic [15:0] cmd, input bit randfill);
        int n, sc, last;
        if (randfill) for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        n = model_n(cmd);
        start_msg(cmd, sc);
        wait_done();
        chk($sformatf("en_count cmd=%04h", cmd), en_q.size(), n + 1);
        if (en_q.size() > 0) begin
            chk("cmd_word", 32'(en_q[0]), {15'd0, 1'b1, cmd});
            chk("start_latency", en_cyc[0] - sc, 1);
        end
        last = (en_q.size() - 1 < n) ? en_q.size() - 1 : n;
        for (int i = 1; i <= last; i++)
            chk($sformatf("data_word %0d", i - 1), 32'(en_q[i]), {15'd0, 1'b0, mem[i-1]});
        chk("rd_count", rd_q.size(), n);
        for (int i = 0; i < rd_q.size() && i < n; i++)
            chk($sformatf("rd_addr %0d", i), rd_q[i], i);
        chk("status_ok", 32'(done_st), 0);
        chk("words", 32'(done_words), n);
        step();
        chk("ready_after_done", 32'(bus.oREADY), 1);
        chk("words_held", 32'(bus.oWORDS), n);
    endtask

    task automatic chk_reset_outputs(input logic exp_ready);
        chk("rst_tx_en", 32'(bus.oTX_EN), 0);
        chk("rst_tx_cd", 32'(bus.oTX_CD), 0);
        chk("rst_tx_data", 32'(bus.oTX_DATA), 0);
        chk("rst_rd", 32'(bus.oRD), 0);
        chk("rst_addr", 32'(bus.oADDR), 0);
        chk("rst_done", 32'(bus.oDONE), 0);
        chk("rst_words", 32'(bus.oWORDS), 0);
        chk("rst_status", 32'(bus.oSTATUS), 0);
        chk("rst_ready", 32'(bus.oREADY), 32'(exp_ready));
    endtask

    initial begin
        logic [15:0] cmd;
        int sc, k, en_before;

        bus.iSTART = 1'b0;
        bus.iCMD   = 16'd0;
        bus.iABORT = 1'b0;
        rst        = 1'b1;
        repeat (3) step();
        chk_reset_outputs(1'b1);
        rst = 1'b0;
        step();

        mem[0] = 16'hAAAA;
        mem[1] = 16'h5555;
        mem[2] = 16'h1234;
        run_msg(16'h0823, 1'b0);
        run_msg(16'h0C23, 1'b1);
        run_msg(16'h0012, 1'b1);
        run_msg(16'h03E2, 1'b1);
        run_msg(16'h0820, 1'b1);

        for (int r = 0; r < 12; r++) begin
            cmd     = 16'($urandom);
            cmd[10] = ($urandom % 4 == 0);
            k       = int'($urandom % 6);
            if (k == 0) cmd[9:5] = 5'd0;
            if (k == 1) cmd[9:5] = 5'h1F;
            run_msg(cmd, 1'b1);
        end

        // Transmitter never answers the command word.
        no_busy = 1;
        start_msg(16'h0823, sc);
        wait_done();
        no_busy = 0;
        chk("to_en_count", en_q.size(), 1);
        if (en_cyc.size() > 0) chk("to_latency", done_cyc - en_cyc[0], BUSY_TO + 2);
        chk("to_rd_count", rd_q.size(), 0);
        chk("to_status", 32'(done_st), 1);
        chk("to_words", 32'(done_words), 0);
        step();
        chk("to_ready_next", 32'(bus.oREADY), 1);

        // Abort during the second data word of a five-word message.
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        start_msg(16'h0825, sc);
        k = 0;
        while (!(en_q.size() == 3 && bus.iTX_BUSY === 1'b1) && k < 500) begin
            step();
            k++;
        end
        chk("abort_reach_word2", en_q.size(), 3);
        bus.iABORT = 1'b1;
        step();
        bus.iABORT = 1'b0;
        wait_done();
        chk("abort_en_count", en_q.size(), 3);
        if (en_q.size() == 3) chk("abort_word2", 32'(en_q[2]), {15'd0, 1'b0, mem[1]});
        chk("abort_status", 32'(done_st), 2);
        chk("abort_words", 32'(done_words), 2);
        chk("abort_rd_count", rd_q.size(), 2);

        // Reset while the first data word is on the bus.
        start_msg(16'h0825, sc);
        k = 0;
        while (!(en_q.size() == 2 && bus.iTX_BUSY === 1'b1) && k < 500) begin
            step();
            k++;
        end
        chk("rst_reach_word1", en_q.size(), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs(1'b0);
        en_before  = en_q.size();
        bus.iCMD   = 16'h0823;
        bus.iSTART = 1'b1;
        step();
        bus.iSTART = 1'b0;
        k = 0;
        while (bus.iTX_BUSY === 1'b1 && k < 100) begin
            chk("ready_low_while_busy", 32'(bus.oREADY), 0);
            step();
            k++;
        end
        chk("ready_after_busy_falls", 32'(bus.oREADY), 1);
        repeat (4) step();
        chk("start_dropped", en_q.size(), en_before);
        chk("no_done_after_reset", 32'(got_done), 0);

        chk("tx_en_while_busy", busy_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
